// File: rtl/datapath_pkg.sv
// Shared types for the datapath slice: operation/select encodings and flag bit positions.
package datapath_pkg;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_SUB  = 3'd1,
    ALU_AND  = 3'd2,
    ALU_OR   = 3'd3,
    ALU_XOR  = 3'd4,
    ALU_NOT  = 3'd5,
    ALU_SHL1 = 3'd6,
    ALU_SHR1 = 3'd7
  } alu_op_t;

  typedef enum logic [1:0] {
    OP2_RS2  = 2'd0,
    OP2_IMM  = 2'd1,
    OP2_ONE  = 2'd2,
    OP2_ZERO = 2'd3
  } op2_sel_t;

  typedef enum logic [1:0] {
    PC_INC = 2'd0,
    PC_ALU = 2'd1,
    PC_LR  = 2'd2,
    PC_BUS = 2'd3
  } pc_sel_t;

  typedef enum logic [1:0] {
    BUS_ALU = 2'd0,
    BUS_PC  = 2'd1,
    BUS_LR  = 2'd2,
    BUS_RS2 = 2'd3
  } bus_sel_t;

  // Bit positions inside the packed {Z,N,C,V} flag word
  localparam int unsigned FLAG_Z = 3;
  localparam int unsigned FLAG_N = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/datapath_alu.sv
// Combinational ALU: result plus zero/negative/carry/overflow flags.
module datapath_alu
  import datapath_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [2:0]       i_op,
  output logic [WIDTH-1:0] o_res,
  output logic             o_z,
  output logic             o_n,
  output logic             o_c,
  output logic             o_v
);

  logic [WIDTH-1:0] w_b_eff;
  logic             w_cin;
  logic [WIDTH:0]   w_sum;
  alu_op_t          w_op;

  assign w_op = alu_op_t'(i_op);

  // SUB shares the adder as A + ~B + 1, so carry-out doubles as "no borrow"
  assign w_b_eff = (w_op == ALU_SUB) ? ~i_b : i_b;
  assign w_cin   = (w_op == ALU_SUB);
  assign w_sum   = {1'b0, i_a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_cin};

  always_comb begin
    o_res = '0;
    o_c   = 1'b0;
    o_v   = 1'b0;
    case (w_op)
      ALU_ADD, ALU_SUB: begin
        o_res = w_sum[WIDTH-1:0];
        o_c   = w_sum[WIDTH];
        o_v   = (i_a[WIDTH-1] == w_b_eff[WIDTH-1]) && (w_sum[WIDTH-1] != i_a[WIDTH-1]);
      end
      ALU_AND:  o_res = i_a & i_b;
      ALU_OR:   o_res = i_a | i_b;
      ALU_XOR:  o_res = i_a ^ i_b;
      ALU_NOT:  o_res = ~i_a;
      ALU_SHL1: begin
        o_res = {i_a[WIDTH-2:0], 1'b0};
        o_c   = i_a[WIDTH-1];
      end
      ALU_SHR1: begin
        o_res = {i_a[WIDTH-1], i_a[WIDTH-1:1]};
        o_c   = i_a[0];
      end
    endcase
  end

  assign o_z = (o_res == '0);
  assign o_n = o_res[WIDTH-1];

endmodule

// File: rtl/datapath_core.sv
// Datapath: register file with hardwired-zero R0, PC/LR unit, operand muxes, ALU,
// registered flags and a registered system-bus driver.
module datapath_core
  import datapath_pkg::*;
#(
  parameter int unsigned      WIDTH    = 16,
  parameter int unsigned      NREGS    = 8,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic                       Clock,
  input  logic                       nReset,
  input  logic [WIDTH-1:0]           SysBusIn,
  output logic [WIDTH-1:0]           SysBusOut,
  output logic                       SysBusEn,
  input  logic [WIDTH-1:0]           Imm,
  input  logic [$clog2(NREGS)-1:0]   Rw,
  input  logic [$clog2(NREGS)-1:0]   Rs1,
  input  logic [$clog2(NREGS)-1:0]   Rs2,
  input  logic                       RegWe,
  input  logic                       WdSel,
  input  logic                       Op1Sel,
  input  logic [1:0]                 Op2Sel,
  input  logic [2:0]                 AluOp,
  input  logic                       FlagWe,
  input  logic                       PcWe,
  input  logic [1:0]                 PcSel,
  input  logic                       LrWe,
  input  logic                       LrSel,
  input  logic                       BusDrv,
  input  logic [1:0]                 BusSel,
  output logic [WIDTH-1:0]           AluOut,
  output logic [WIDTH-1:0]           Pc,
  output logic [WIDTH-1:0]           Lr,
  output logic [3:0]                 Flags
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_regs [NREGS];
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_lr;
  logic [3:0]       r_flags;
  logic [WIDTH-1:0] r_bus_out;
  logic             r_bus_en;

  logic [WIDTH-1:0] w_rs1;
  logic [WIDTH-1:0] w_rs2;
  logic [WIDTH-1:0] w_op_a;
  logic [WIDTH-1:0] w_op_b;
  logic [WIDTH-1:0] w_alu;
  logic [WIDTH-1:0] w_pc_inc;
  logic [WIDTH-1:0] w_wdata;
  logic [WIDTH-1:0] w_pc_next;
  logic [WIDTH-1:0] w_bus_src;
  logic             w_z, w_n, w_c, w_v;

  assign w_rs1    = (Rs1 == '0) ? '0 : r_regs[Rs1];
  assign w_rs2    = (Rs2 == '0) ? '0 : r_regs[Rs2];
  assign w_op_a   = Op1Sel ? r_pc : w_rs1;
  assign w_pc_inc = r_pc + ONE;
  assign w_wdata  = WdSel ? SysBusIn : w_alu;

  always_comb begin
    w_op_b = '0;
    case (op2_sel_t'(Op2Sel))
      OP2_RS2:  w_op_b = w_rs2;
      OP2_IMM:  w_op_b = Imm;
      OP2_ONE:  w_op_b = ONE;
      OP2_ZERO: w_op_b = '0;
    endcase
  end

  always_comb begin
    w_pc_next = w_pc_inc;
    case (pc_sel_t'(PcSel))
      PC_INC: w_pc_next = w_pc_inc;
      PC_ALU: w_pc_next = w_alu;
      PC_LR:  w_pc_next = r_lr;
      PC_BUS: w_pc_next = SysBusIn;
    endcase
  end

  always_comb begin
    w_bus_src = w_alu;
    case (bus_sel_t'(BusSel))
      BUS_ALU: w_bus_src = w_alu;
      BUS_PC:  w_bus_src = r_pc;
      BUS_LR:  w_bus_src = r_lr;
      BUS_RS2: w_bus_src = w_rs2;
    endcase
  end

  datapath_alu #(
    .WIDTH(WIDTH)
  ) u_alu (
    .i_a   (w_op_a),
    .i_b   (w_op_b),
    .i_op  (AluOp),
    .o_res (w_alu),
    .o_z   (w_z),
    .o_n   (w_n),
    .o_c   (w_c),
    .o_v   (w_v)
  );

  // R0 storage is never written; the read muxes force it to zero regardless
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      r_regs <= '{default: '0};
    end else if (RegWe && (Rw != '0)) begin
      r_regs[Rw] <= w_wdata;
    end
  end

  // LR samples pre-update PC+1/ALU, so a same-cycle PC write gives call-link semantics
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      r_pc <= RESET_PC;
      r_lr <= '0;
    end else begin
      if (PcWe) r_pc <= w_pc_next;
      if (LrWe) r_lr <= LrSel ? w_alu : w_pc_inc;
    end
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      r_flags <= '0;
    end else if (FlagWe) begin
      r_flags[FLAG_Z] <= w_z;
      r_flags[FLAG_N] <= w_n;
      r_flags[FLAG_C] <= w_c;
      r_flags[FLAG_V] <= w_v;
    end
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      r_bus_out <= '0;
      r_bus_en  <= 1'b0;
    end else begin
      r_bus_en <= BusDrv;
      if (BusDrv) r_bus_out <= w_bus_src;
    end
  end

  assign AluOut    = w_alu;
  assign Pc        = r_pc;
  assign Lr        = r_lr;
  assign Flags     = r_flags;
  assign SysBusOut = r_bus_out;
  assign SysBusEn  = r_bus_en;

endmodule
